// File: rtl/prog_run_ctrl.sv
// BRISC run controller: streams a program into IMEM, then gates PC advance
// through load_done/halt for free-run, single-step and stop.
module prog_run_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 8,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic              run,
   input  logic              step,
   input  logic              halt_req,
   input  logic              halt_instr,
   input  logic [PC_W-1:0]   pc,
   output logic              load_done,
   output logic              halt,
   output logic [2:0]        state,
   output logic [ADDR_W:0]   load_count,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RUN    = 3'd2,
      S_STEP   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]  LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [PC_W-1:0]  PC_STOP   = PC_W'((1 << ADDR_W) - 1);

   state_t            st;
   logic              stop;
   logic              last_word;
   logic [CNT_W-1:0]  cnt_next;

   // Write pointer is the low bits of load_count; it never wraps because
   // the load ends on the word at the last address.
   assign state      = st;
   assign ld_ready   = (st == S_LOAD);
   assign imem_we    = ld_valid & ld_ready;
   assign imem_addr  = load_count[ADDR_W-1:0];
   assign imem_wdata = ld_data;

   assign stop      = halt_req | halt_instr | (pc == PC_STOP);
   assign last_word = ld_last | (load_count == LAST_ADDR);
   assign cnt_next  = (cycle_count == '1) ? cycle_count
                                          : cycle_count + 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st          <= S_IDLE;
         load_done   <= 1'b0;
         halt        <= 1'b1;
         load_count  <= '0;
         cycle_count <= '0;
      end else begin
         unique case (st)
            S_IDLE: begin
               if (ld_start) begin
                  st         <= S_LOAD;
                  load_count <= '0;
               end
            end
            S_LOAD: begin
               if (ld_valid) begin
                  load_count <= load_count + 1'b1;
                  if (last_word) begin
                     st          <= S_HALTED;
                     load_done   <= 1'b1;
                     cycle_count <= '0;
                  end
               end
            end
            S_HALTED: begin
               if (ld_start) begin
                  st         <= S_LOAD;
                  load_done  <= 1'b0;
                  load_count <= '0;
               end else if (step) begin
                  st   <= S_STEP;
                  halt <= 1'b0;
               end else if (run) begin
                  st   <= S_RUN;
                  halt <= 1'b0;
               end
            end
            S_STEP: begin
               st          <= S_HALTED;
               halt        <= 1'b1;
               cycle_count <= cnt_next;
            end
            S_RUN: begin
               cycle_count <= cnt_next;
               if (stop) begin
                  st   <= S_HALTED;
                  halt <= 1'b1;
               end
            end
            default: begin
               st   <= S_IDLE;
               halt <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: load, overflow load, step, run/stop,
// reload priority and asynchronous reset mid-load.
module tb_prog_run_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int PC_W   = 8;
   localparam int CNT_W  = 16;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              ld_start = 1'b0;
   logic              ld_valid = 1'b0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_last = 1'b0;
   logic              ld_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic              run = 1'b0;
   logic              step = 1'b0;
   logic              halt_req = 1'b0;
   logic              halt_instr = 1'b0;
   logic [PC_W-1:0]   pc = '0;
   logic              load_done;
   logic              halt;
   logic [2:0]        state;
   logic [ADDR_W:0]   load_count;
   logic [CNT_W-1:0]  cycle_count;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int low_count = 0;
   int wr_saved;
   logic [DATA_W-1:0] mem [32];

   prog_run_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .run(run), .step(step), .halt_req(halt_req),
      .halt_instr(halt_instr), .pc(pc),
      .load_done(load_done), .halt(halt), .state(state),
      .load_count(load_count), .cycle_count(cycle_count)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wr_count <= wr_count + 1;
      end
   end

   always @(negedge CLK) begin
      if (!halt) low_count <= low_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      #12;
      chk("rst_state", 32'(state), 0);
      chk("rst_load_done", 32'(load_done), 0);
      chk("rst_halt", 32'(halt), 1);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_imem_we", 32'(imem_we), 0);
      chk("rst_imem_addr", 32'(imem_addr), 0);
      chk("rst_load_count", 32'(load_count), 0);
      chk("rst_cycle_count", 32'(cycle_count), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();

      // 1: short load ending on ld_last
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("t1_state_load", 32'(state), 1);
      chk("t1_ld_ready", 32'(ld_ready), 1);
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1'b1;
         ld_data  = DATA_W'(16'h1001 + i);
         ld_last  = (i == 4);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      tick();
      chk("t1_writes", 32'(wr_count), 5);
      chk("t1_mem0", 32'(mem[0]), 32'h1001);
      chk("t1_mem4", 32'(mem[4]), 32'h1005);
      chk("t1_load_count", 32'(load_count), 5);
      chk("t1_state", 32'(state), 4);
      chk("t1_load_done", 32'(load_done), 1);
      chk("t1_halt", 32'(halt), 1);

      // 2: 40 words without ld_last, capped at 32
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("t2_load_done_low", 32'(load_done), 0);
      wr_count = 0;
      for (int i = 0; i < 40; i++) begin
         ld_valid = 1'b1;
         ld_data  = DATA_W'(16'h2000 + i);
         tick();
      end
      ld_valid = 1'b0;
      tick();
      chk("t2_writes", 32'(wr_count), 32);
      chk("t2_mem0", 32'(mem[0]), 32'h2000);
      chk("t2_mem31", 32'(mem[31]), 32'h201f);
      chk("t2_state", 32'(state), 4);
      chk("t2_ld_ready", 32'(ld_ready), 0);
      chk("t2_load_count", 32'(load_count), 32);
      chk("t2_cycle_count", 32'(cycle_count), 0);

      // 3: three single steps
      low_count = 0;
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         chk("t3_step_halt", 32'(halt), 0);
         chk("t3_step_state", 32'(state), 3);
         tick();
         chk("t3_back_halt", 32'(halt), 1);
         chk("t3_back_state", 32'(state), 4);
         tick();
         tick();
      end
      chk("t3_low_cycles", 32'(low_count), 3);
      chk("t3_cycle_count", 32'(cycle_count), 3);

      // 4a: free run until pc reaches the last address
      pc  = '0;
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("t4_run_state", 32'(state), 2);
      chk("t4_run_halt", 32'(halt), 0);
      for (int p = 0; p < 32; p++) begin
         pc = PC_W'(p);
         tick();
         if (p == 30) chk("t4_pc30_halt", 32'(halt), 0);
      end
      chk("t4_pc31_halt", 32'(halt), 1);
      chk("t4_pc31_state", 32'(state), 4);
      chk("t4_cycle_count", 32'(cycle_count), 35);

      // 4b: HALT opcode at pc 7
      pc  = '0;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int p = 0; p < 8; p++) begin
         pc = PC_W'(p);
         halt_instr = (p == 7);
         tick();
         if (p == 6) chk("t4b_pc6_halt", 32'(halt), 0);
      end
      halt_instr = 1'b0;
      chk("t4b_halt", 32'(halt), 1);
      chk("t4b_state", 32'(state), 4);
      chk("t4b_cycle_count", 32'(cycle_count), 43);

      // 4c: host stop request
      pc  = 8'd3;
      run = 1'b1;
      tick();
      run = 1'b0;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("t4c_state", 32'(state), 4);
      chk("t4c_cycle_count", 32'(cycle_count), 44);

      // 5: reload beats run
      ld_start = 1'b1;
      run      = 1'b1;
      tick();
      ld_start = 1'b0;
      run      = 1'b0;
      chk("t5_state", 32'(state), 1);
      chk("t5_load_done", 32'(load_done), 0);
      chk("t5_halt", 32'(halt), 1);

      // 6: async reset after 3 words
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = DATA_W'(16'h3000 + i);
         tick();
      end
      chk("t6_pre_count", 32'(load_count), 3);
      #2;
      RST_N = 1'b0;
      #1;
      chk("t6_state", 32'(state), 0);
      chk("t6_load_done", 32'(load_done), 0);
      chk("t6_halt", 32'(halt), 1);
      chk("t6_load_count", 32'(load_count), 0);
      chk("t6_imem_we", 32'(imem_we), 0);
      wr_saved = wr_count;
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      tick();
      ld_valid = 1'b0;
      chk("t6_no_writes", 32'(wr_count), 32'(wr_saved));
      chk("t6_idle", 32'(state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
